// File: rtl/cpu_pipe_pkg.sv
// ============================================================================
// Module      : cpu_pipe_pkg
// Description : Shared pipeline-stage types: handshake stage state encoding,
//               per-boundary payload structs and a state-to-occupancy helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pipe_pkg;

    // Number of entries held by a stage register, encoded so the value doubles
    // as the occupancy count.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } stage_state_e;

    // IF/ID boundary payload
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // ID/EX boundary payload
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [5:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    // EX/MEM boundary payload
    typedef struct packed {
        logic [63:0] alu_res;
        logic [63:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    // MEM/WB boundary payload
    typedef struct packed {
        logic [63:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    // Entries held for a given state (0, 1 or 2).
    function automatic logic [1:0] occ_of(input stage_state_e st);
        case (st)
            PS_ONE:  occ_of = 2'd1;
            PS_TWO:  occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its maximum value instead of wrapping.
//               Cleared only by the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count up on each qualifying cycle, holding once all ones is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline stage register with valid/ready handshake, two-entry
//               skid buffer, flush, stall and a saturating bubble counter.
//               in_ready is a function of state flops and stall only, which
//               cuts the backpressure path between adjacent stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);

    stage_state_e     state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    // Handshake terms come from state flops and stall only, never out_ready
    assign in_ready  = (state_q != PS_TWO)   && !stall;
    assign out_valid = (state_q != PS_EMPTY) && !stall;
    assign in_fire   = in_valid  && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);

    // State and payload update; flush wins over every other condition and
    // leaves payload registers untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PS_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= PS_EMPTY;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_q <= PS_ONE;
                        main_q  <= in_data;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q  <= in_data;
                    end else if (in_fire) begin
                        state_q <= PS_TWO;
                        skid_q  <= in_data;
                    end else if (out_fire) begin
                        state_q <= PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    // in_ready is low here, so only the drain can happen
                    if (out_fire) begin
                        state_q <= PS_ONE;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= PS_EMPTY;
                end
            endcase
        end
    end

    // Bubble: downstream ready but nothing valid to give it (stall included)
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_ready && !out_valid),
        .count (bubble_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        stall;
    logic        flush;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    logic        s_reset;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occupancy;
    logic [1:0]  s_bubble_cnt;

    int passed = 0;
    int total  = 0;

    pipe_stage_reg #(
        .WIDTH (64),
        .CNT_W (16)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall      (stall),
        .flush      (flush),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_reg #(
        .WIDTH (8),
        .CNT_W (2)
    ) u_sat (
        .clk        (clk),
        .reset      (s_reset),
        .in_valid   (1'b0),
        .in_ready   (s_in_ready),
        .in_data    (8'h00),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_data   (s_out_data),
        .stall      (1'b0),
        .flush      (1'b0),
        .occupancy  (s_occupancy),
        .bubble_cnt (s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        s_reset     = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        s_out_ready = 1'b0;
        #1;
        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data,        64'd0);
        chk("rst_occ",       64'(occupancy),  64'd0);
        chk("rst_in_ready",  64'(in_ready),   64'd1);
        chk("rst_bubble",    64'(bubble_cnt), 64'd0);
        tick();
        reset = 1'b1;

        // Load 0x1234, then assert reset between edges
        in_valid = 1'b1;
        in_data  = 64'h1234;
        tick();
        chk("load_out_data",  out_data,        64'h1234);
        chk("load_out_valid", 64'(out_valid),  64'd1);
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_data",  out_data,        64'd0);
        chk("async_rst_occ",       64'(occupancy),  64'd0);
        reset = 1'b1;
        tick();

        // Streaming 1,2,3 with out_ready high; first edge counts one bubble
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h1;
        tick();
        chk("stream1_data", out_data,        64'h1);
        chk("stream1_occ",  64'(occupancy),  64'd1);
        chk("stream1_bub",  64'(bubble_cnt), 64'd1);
        in_data = 64'h2;
        tick();
        chk("stream2_data", out_data,        64'h2);
        chk("stream2_occ",  64'(occupancy),  64'd1);
        in_data = 64'h3;
        tick();
        chk("stream3_data", out_data,        64'h3);
        chk("stream3_occ",  64'(occupancy),  64'd1);
        chk("stream3_bub",  64'(bubble_cnt), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("drain_valid",  64'(out_valid),  64'd0);
        chk("drain_bub",    64'(bubble_cnt), 64'd1);

        // Backpressure: fill with A, B, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        in_data = 64'hB;
        tick();
        chk("bp_occ",      64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready),  64'd0);
        chk("bp_head_a",   out_data,       64'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_head_b",   out_data,       64'hB);
        chk("bp_occ1",     64'(occupancy), 64'd1);
        chk("bp_valid_b",  64'(out_valid), 64'd1);
        tick();
        chk("bp_empty",    64'(out_valid), 64'd0);
        chk("bp_bub",      64'(bubble_cnt), 64'd1);

        // Stall: hold 0x5 for three stalled cycles with out_ready high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall     = 1'b1;
        #1;
        chk("stall_out_valid", 64'(out_valid), 64'd0);
        chk("stall_in_ready",  64'(in_ready),  64'd0);
        tick();
        tick();
        tick();
        chk("stall_bub",  64'(bubble_cnt), 64'd4);
        chk("stall_occ",  64'(occupancy),  64'd1);
        stall = 1'b0;
        #1;
        chk("unstall_valid", 64'(out_valid), 64'd1);
        chk("unstall_data",  out_data,       64'h5);
        tick();
        chk("unstall_occ", 64'(occupancy),  64'd0);
        chk("unstall_bub", 64'(bubble_cnt), 64'd4);

        // Flush priority from TWO with stall, in_valid and out_ready all high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h10;
        tick();
        in_data = 64'h11;
        tick();
        chk("fl_pre_occ", 64'(occupancy), 64'd2);
        flush     = 1'b1;
        stall     = 1'b1;
        in_data   = 64'hF;
        out_ready = 1'b1;
        #1;
        chk("fl_cycle_occ", 64'(occupancy), 64'd2);
        tick();
        chk("fl_occ",   64'(occupancy),  64'd0);
        chk("fl_valid", 64'(out_valid),  64'd0);
        chk("fl_bub",   64'(bubble_cnt), 64'd5);
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_payload_kept", out_data,        64'h10);
        chk("fl_post_bub",     64'(bubble_cnt), 64'd6);

        // Flush from EMPTY with in_valid: incoming word dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h22;
        flush     = 1'b1;
        tick();
        chk("fl_drop_occ",  64'(occupancy), 64'd0);
        chk("fl_drop_data", out_data,       64'h10);
        flush    = 1'b0;
        in_valid = 1'b0;

        // Saturation on the 2-bit counter instance
        s_reset     = 1'b1;
        s_out_ready = 1'b1;
        #1;
        chk("sat_in_ready",  64'(s_in_ready),  64'd1);
        chk("sat_out_valid", 64'(s_out_valid), 64'd0);
        chk("sat_out_data",  64'(s_out_data),  64'd0);
        chk("sat_occ",       64'(s_occupancy), 64'd0);
        tick();
        chk("sat_1", 64'(s_bubble_cnt), 64'd1);
        tick();
        chk("sat_2", 64'(s_bubble_cnt), 64'd2);
        tick();
        chk("sat_3", 64'(s_bubble_cnt), 64'd3);
        tick();
        chk("sat_4", 64'(s_bubble_cnt), 64'd3);
        tick();
        chk("sat_5", 64'(s_bubble_cnt), 64'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Runaway guard
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer, synchronous flush and stall, and a saturating bubble counter. It replaces the fixed-field IF_ID / ID_EX / EX_MEM / MEM_WB latches. Each stage boundary of the 64-bit CPU instantiates one copy, with that stage's payload packed into `data`. The registered `in_ready` breaks the backpressure path between stages, so hazard logic can stall or squash a stage without combinational loops.

## Interface
- `WIDTH`, default 64: payload width in bits, at least 1.
- `CNT_W`, default 16: bubble counter width, at least 1.
- `clk`  in  1: clock, rising-edge active.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: upstream presents `in_data`.
- `in_ready`  out  1: stage can accept `in_data` this cycle.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts `out_data`.
- `out_data`  out  WIDTH: payload at the head of the stage.
- `stall`  in  1: freezes the stage; no transfer on either side.
- `flush`  in  1: squashes every held entry.
- `occupancy`  out  2: number of entries held, 0 to 2.
- `bubble_cnt`  out  CNT_W: saturating count of cycles in which the stage had nothing to give a ready downstream.

## Operation
- **Storage:**
  - Main register `main_q`, which drives `out_data`.
  - Skid register `skid_q`.
  - State: EMPTY, ONE or TWO.
- **Handshake:**
  - `in_ready = (state != TWO) & ~stall`.
  - `out_valid = (state != EMPTY) & ~stall`.
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
- **Transitions**, evaluated when `flush = 0`:
  - EMPTY, `in_fire`: go to ONE, `main_q <= in_data`.
  - ONE, `in_fire & out_fire`: stay in ONE, `main_q <= in_data`.
  - ONE, `in_fire & ~out_fire`: go to TWO, `skid_q <= in_data`.
  - ONE, `~in_fire & out_fire`: go to EMPTY.
  - TWO, `out_fire`: go to ONE, `main_q <= skid_q`. No input is accepted because `in_ready = 0`.
  - Any other combination: hold state and data.
- **Stall:** with `stall = 1`, both fires are 0 and the state holds. The downstream sees a bubble and the upstream sees backpressure.
- **Flush:**
  - `flush = 1` moves the state to EMPTY on the next edge.
  - Flush takes priority over `stall`, `in_fire` and `out_fire` in the same cycle.
  - The payload registers are not cleared by flush.
  - During the flush cycle the outputs still reflect the current state. Downstream must qualify with its own flush if required.
- **Occupancy:** 0, 1 or 2 for EMPTY, ONE or TWO.
- **Bubble counter:**
  - Increments when `out_ready & ~out_valid` (this includes stall cycles).
  - Saturates at 2^CNT_W − 1 and does not wrap.
  - Cleared only by reset.
- **Ordering:** payloads leave in arrival order. There is no loss and no duplication.

## Timing
- **Reset values:** `reset = 0` asynchronously forces:
  - state EMPTY, `main_q = 0`, `skid_q = 0`, `bubble_cnt = 0`;
  - therefore `out_valid = 0`, `out_data = 0`, `occupancy = 0`;
  - `in_ready = ~stall`.
- **Reset mid-operation:** held entries are lost and the stage accepts input on the first edge after `reset` deasserts.
- **Latency:** `in_data` accepted on edge N appears on `out_data` with `out_valid` after edge N, when the stage was EMPTY, or ONE and draining.
- **Throughput:** with `out_ready` held at 1 and no stall, one transfer per cycle.
- **Combinational paths:** `in_ready` depends on the state flops and `stall` only, never on `out_ready`. `out_valid` and `out_data` depend on flops and `stall` only.
- **Full condition:** in TWO, upstream is held off for at least one cycle.
- **Simultaneous flush with `in_valid`:** the incoming word is dropped even though `in_ready` was 1. Upstream treats that word as squashed.

## Structure
- **Shared package `cpu_pipe_pkg`:**
  - the state enum (`PS_EMPTY`, `PS_ONE`, `PS_TWO`);
  - the packed per-stage payload structs (IF/ID, ID/EX, EX/MEM, MEM/WB), whose `$bits` sets `WIDTH` at each instance.
- **Sub-module:** `sat_counter` (parameter `CNT_W`; inputs `inc` and `reset`) holds the bubble counter logic.
- **Remainder:** the handshake, state machine and data registers, in a single `always_ff` with asynchronous reset.

## Test plan
- **Reset:** set `main_q = 0x1234` with `reset` high, then drop `reset` between edges → `out_valid = 0`, `out_data = 0` and `occupancy = 0` immediately, without waiting for an edge.
- **Streaming:** `in_valid` = 1 and `out_ready` = 1 for words 0x1, 0x2, 0x3 on consecutive cycles → `out_data` shows 0x1, 0x2, 0x3 one cycle later, `occupancy = 1` throughout, `bubble_cnt` unchanged.
- **Backpressure:** `out_ready = 0` while sending 0xA, 0xB → `occupancy = 2`, `in_ready = 0`. Then set `out_ready = 1` → 0xA, then 0xB, then `out_valid = 0`.
- **Stall:** hold 0x5 in ONE and assert `stall` for 3 cycles with `out_ready = 1` → no `out_fire`, `bubble_cnt` += 3, 0x5 delivered after stall drops.
- **Flush priority:** state TWO, assert `flush`, `stall`, `in_valid` (0xF) and `out_ready` together → next cycle EMPTY, 0xF never appears on the output.
- **Counter saturation:** `CNT_W = 2` with 5 bubble cycles → `bubble_cnt` reads 1, 2, 3, 3, 3.
